// File: rtl/debug_controller_if.sv
// Bus between the debug controller and its surroundings (command decoder, MCU, memory, RF).
// slave is the controller's view; master is the decoder/MCU side that drives it.
`timescale 1ns/1ps
interface debug_controller_if;
  logic [3:0]  cmd;
  logic [31:0] addr;
  logic [31:0] d_in;
  logic        in_valid;
  logic        ctrlr_busy;
  logic [31:0] d_rd;
  logic        rd_valid;
  logic        err;
  logic        mcu_pause;
  logic        mcu_paused;
  logic        mcu_reset;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic        rf_we;
  logic [31:0] rf_rdata;

  modport slave (
    input  cmd, addr, d_in, in_valid, mcu_paused, mem_rdata, mem_ack, rf_rdata,
    output ctrlr_busy, d_rd, rd_valid, err, mcu_pause, mcu_reset,
           mem_addr, mem_wdata, mem_re, mem_we, rf_addr, rf_wdata, rf_we
  );

  modport master (
    output cmd, addr, d_in, in_valid, mcu_paused, mem_rdata, mem_ack, rf_rdata,
    input  ctrlr_busy, d_rd, rd_valid, err, mcu_pause, mcu_reset,
           mem_addr, mem_wdata, mem_re, mem_we, rf_addr, rf_wdata, rf_we
  );
endinterface

// File: rtl/debug_controller.sv
// Executes one decoded debug command against the MCU (pause/resume, reset,
// memory and register-file access, status) and reports read data or an error pulse.
`timescale 1ns/1ps
module debug_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned RESET_CYCLES   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  debug_controller_if.slave bus
);
  localparam int unsigned CNT_TOP = (TIMEOUT_CYCLES > RESET_CYCLES) ? TIMEOUT_CYCLES : RESET_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_TOP + 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);

  localparam logic [3:0] CMD_NOP    = 4'd0;
  localparam logic [3:0] CMD_PAUSE  = 4'd1;
  localparam logic [3:0] CMD_RESUME = 4'd2;
  localparam logic [3:0] CMD_RESET  = 4'd3;
  localparam logic [3:0] CMD_STATUS = 4'd4;
  localparam logic [3:0] CMD_MEM_RD = 4'd5;
  localparam logic [3:0] CMD_MEM_WR = 4'd6;
  localparam logic [3:0] CMD_REG_RD = 4'd7;
  localparam logic [3:0] CMD_REG_WR = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_PAUSE, S_MEM, S_RF_RD, S_RST_HOLD, S_DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             busy_q, rd_valid_q, err_q;
  logic             mcu_pause_q, mcu_reset_q;
  logic             mem_re_q, mem_we_q, rf_we_q;
  logic [31:0]      d_rd_q, mem_addr_q, mem_wdata_q, rf_wdata_q;
  logic [4:0]       rf_addr_q;
  logic             mem_ok;

  // Saturating so a stuck wait can never wrap back into a short count.
  assign cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign mem_ok = bus.mcu_paused && (bus.addr[1:0] == 2'b00);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      mcu_pause_q <= 1'b0;
      mcu_reset_q <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      rf_we_q     <= 1'b0;
      d_rd_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rf_addr_q   <= '0;
      rf_wdata_q  <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      rf_we_q    <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_DONE;
            unique case (bus.cmd)
              CMD_NOP: ;
              CMD_PAUSE: begin
                mcu_pause_q <= 1'b1;
                state_q     <= S_WAIT_PAUSE;
              end
              CMD_RESUME: mcu_pause_q <= 1'b0;
              CMD_RESET: begin
                mcu_reset_q <= 1'b1;
                state_q     <= S_RST_HOLD;
              end
              CMD_STATUS: begin
                d_rd_q     <= {31'b0, bus.mcu_paused};
                rd_valid_q <= 1'b1;
              end
              CMD_MEM_RD, CMD_MEM_WR: begin
                if (mem_ok) begin
                  mem_addr_q  <= bus.addr;
                  mem_wdata_q <= bus.d_in;
                  mem_re_q    <= (bus.cmd == CMD_MEM_RD);
                  mem_we_q    <= (bus.cmd == CMD_MEM_WR);
                  state_q     <= S_MEM;
                end else begin
                  err_q <= 1'b1;
                end
              end
              CMD_REG_RD: begin
                if (bus.mcu_paused) begin
                  rf_addr_q <= bus.addr[4:0];
                  state_q   <= S_RF_RD;
                end else begin
                  err_q <= 1'b1;
                end
              end
              CMD_REG_WR: begin
                if (bus.mcu_paused) begin
                  rf_addr_q  <= bus.addr[4:0];
                  rf_wdata_q <= bus.d_in;
                  rf_we_q    <= 1'b1;
                end else begin
                  err_q <= 1'b1;
                end
              end
              default: err_q <= 1'b1;
            endcase
          end
        end
        S_WAIT_PAUSE: begin
          if (bus.mcu_paused) begin
            cnt_q   <= '0;
            state_q <= S_DONE;
          end else if (cnt_q == TO_LAST) begin
            // mcu_pause deliberately stays asserted after a pause timeout
            err_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_MEM: begin
          if (bus.mem_ack) begin
            if (mem_re_q) begin
              d_rd_q     <= bus.mem_rdata;
              rd_valid_q <= 1'b1;
            end
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= S_DONE;
          end else if (cnt_q == TO_LAST) begin
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;
            err_q    <= 1'b1;
            cnt_q    <= '0;
            state_q  <= S_DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_RF_RD: begin
          d_rd_q     <= bus.rf_rdata;
          rd_valid_q <= 1'b1;
          state_q    <= S_DONE;
        end
        S_RST_HOLD: begin
          if (cnt_q == RST_LAST) begin
            mcu_reset_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ctrlr_busy = busy_q;
  assign bus.d_rd       = d_rd_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.err        = err_q;
  assign bus.mcu_pause  = mcu_pause_q;
  assign bus.mcu_reset  = mcu_reset_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_re     = mem_re_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.rf_addr    = rf_addr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.rf_we      = rf_we_q;
endmodule

// File: tb/tb_debug_controller.sv
// Randomized scoreboard bench for debug_controller with MCU, memory and RF models.
`timescale 1ns/1ps
module tb_debug_controller;
  localparam int TO = 255;
  localparam int RC = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  debug_controller_if bus();
  debug_controller #(.TIMEOUT_CYCLES(TO), .RESET_CYCLES(RC)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  typedef struct {
    int          id;
    logic [3:0]  c;
    int          busy_len;
    int          err_n;
    int          rdv_n;
    logic [31:0] d_rd;
    int          re_cyc;
    int          we_cyc;
    int          rfwe_cyc;
    int          rst_cyc;
    logic        pause;
    logic [31:0] maddr;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   n_issued = 0;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cmd#%0d actual=0x%08h required=0x%08h", nm, id, act, exp);
    end
  endtask

  // ---------------- environment: MCU stall, memory, register file ----------------
  int   pause_delay = 1;   // 0 means the MCU never acknowledges
  int   pause_cnt = 0;
  logic paused_m = 1'b0;
  always @(posedge clk) begin
    if (!bus.mcu_pause) begin
      pause_cnt <= 0;
      paused_m  <= 1'b0;
    end else if (!paused_m) begin
      if (pause_delay != 0 && pause_cnt + 1 == pause_delay) paused_m <= 1'b1;
      pause_cnt <= pause_cnt + 1;
    end
  end
  assign bus.mcu_paused = paused_m;

  int          ack_n = 1;  // ack in this strobe cycle; 0 means never
  int          scnt = 0;
  logic [31:0] env_mem [64];
  always @(negedge clk) begin
    if (bus.mem_re || bus.mem_we) begin
      scnt = scnt + 1;
      bus.mem_ack   = (ack_n != 0 && scnt == ack_n);
      bus.mem_rdata = bus.mem_ack ? env_mem[bus.mem_addr[7:2]] : $urandom;
    end else begin
      scnt = 0;
      bus.mem_ack   = ($urandom_range(0, 7) == 0);
      bus.mem_rdata = $urandom;
    end
  end
  always @(posedge clk)
    if (bus.mem_we && bus.mem_ack) env_mem[bus.mem_addr[7:2]] <= bus.mem_wdata;

  logic [31:0] env_rf [32];
  always @(posedge clk)
    if (bus.rf_we && bus.rf_addr != 5'd0) env_rf[bus.rf_addr] <= bus.rf_wdata;
  assign bus.rf_rdata = (bus.rf_addr == 5'd0) ? 32'd0 : env_rf[bus.rf_addr];

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [64];
  logic [31:0] ref_rf [32];
  logic [31:0] ref_last_rd = 32'd0;
  logic        ref_pause = 1'b0;

  function automatic exp_t predict(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d,
                                   input logic p, input int pd, input int an);
    exp_t e;
    int   s;
    e = '{default: 0};
    e.busy_len = 1;
    case (c)
      4'd0: ;
      4'd1: begin
        if (p) s = 1;
        else if (pd == 0 || pd + 1 > TO) begin s = TO; e.err_n = 1; end
        else s = pd + 1;
        e.busy_len = s + 1;
        ref_pause = 1'b1;
      end
      4'd2: ref_pause = 1'b0;
      4'd3: begin e.busy_len = RC + 1; e.rst_cyc = RC; end
      4'd4: begin e.rdv_n = 1; ref_last_rd = {31'd0, p}; end
      4'd5, 4'd6: begin
        if (!p || a[1:0] != 2'b00) e.err_n = 1;
        else begin
          if (an == 0 || an > TO) begin s = TO; e.err_n = 1; end
          else s = an;
          e.busy_len = s + 1;
          e.maddr = a;
          if (c == 4'd5) begin
            e.re_cyc = s;
            if (e.err_n == 0) begin e.rdv_n = 1; ref_last_rd = ref_mem[a[7:2]]; end
          end else begin
            e.we_cyc = s;
            if (e.err_n == 0) ref_mem[a[7:2]] = d;
          end
        end
      end
      4'd7: begin
        if (!p) e.err_n = 1;
        else begin
          e.busy_len = 2;
          e.rdv_n = 1;
          ref_last_rd = (a[4:0] == 5'd0) ? 32'd0 : ref_rf[a[4:0]];
        end
      end
      4'd8: begin
        if (!p) e.err_n = 1;
        else begin
          e.rfwe_cyc = 1;
          if (a[4:0] != 5'd0) ref_rf[a[4:0]] = d;
        end
      end
      default: e.err_n = 1;
    endcase
    e.d_rd  = ref_last_rd;
    e.pause = ref_pause;
    return e;
  endfunction

  // ---------------- monitor ----------------
  bit          mon_en = 1'b0;
  logic        prev_busy = 1'b0;
  int          m_busy, m_re, m_we, m_rfwe, m_rst, m_err, m_rdv;
  logic [31:0] m_maddr;
  exp_t        mon_e;

  task automatic mon_clear();
    m_busy = 0; m_re = 0; m_we = 0; m_rfwe = 0; m_rst = 0; m_err = 0; m_rdv = 0;
    m_maddr = 32'd0;
  endtask

  always @(negedge clk) begin
    if (!mon_en) begin
      mon_clear();
      prev_busy = 1'b0;
    end else begin
      if (bus.ctrlr_busy) m_busy++;
      if (bus.mem_re) begin m_re++; m_maddr = bus.mem_addr; end
      if (bus.mem_we) begin m_we++; m_maddr = bus.mem_addr; end
      if (bus.rf_we) m_rfwe++;
      if (bus.mcu_reset) m_rst++;
      if (bus.err) m_err++;
      if (bus.rd_valid) m_rdv++;
      if (prev_busy && !bus.ctrlr_busy) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_completion busy_cycles=%0d required=none", m_busy);
        end else begin
          mon_e = sb_q.pop_front();
          $display("cmd#%0d code=%0d busy=%0d err=%0d rdv=%0d d_rd=0x%08h re=%0d we=%0d rst=%0d",
                   mon_e.id, mon_e.c, m_busy, m_err, m_rdv, bus.d_rd, m_re, m_we, m_rst);
          chk("busy_len", mon_e.id, m_busy, mon_e.busy_len);
          chk("err_pulses", mon_e.id, m_err, mon_e.err_n);
          chk("rd_valid_pulses", mon_e.id, m_rdv, mon_e.rdv_n);
          chk("d_rd", mon_e.id, bus.d_rd, mon_e.d_rd);
          chk("mem_re_cycles", mon_e.id, m_re, mon_e.re_cyc);
          chk("mem_we_cycles", mon_e.id, m_we, mon_e.we_cyc);
          chk("rf_we_cycles", mon_e.id, m_rfwe, mon_e.rfwe_cyc);
          chk("mcu_reset_cycles", mon_e.id, m_rst, mon_e.rst_cyc);
          chk("mcu_pause", mon_e.id, bus.mcu_pause, mon_e.pause);
          if (mon_e.re_cyc + mon_e.we_cyc > 0) chk("mem_addr", mon_e.id, m_maddr, mon_e.maddr);
        end
        mon_clear();
      end
      prev_busy = bus.ctrlr_busy;
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((bus.ctrlr_busy || sb_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL idle_timeout actual_busy=%0d pending=%0d required=idle", bus.ctrlr_busy, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d,
                       input int pd, input int an, input bit poke);
    exp_t e;
    wait_idle(600);
    pause_delay = pd;
    ack_n = an;
    e = predict(c, a, d, bus.mcu_paused, pd, an);
    e.id = n_issued;
    e.c = c;
    n_issued++;
    sb_q.push_back(e);
    bus.cmd = c; bus.addr = a; bus.d_in = d; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.cmd = 4'($urandom); bus.addr = $urandom; bus.d_in = $urandom;
    // a strobe while busy must be dropped, not queued
    if (poke) begin
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd = 4'd0; bus.addr = 32'd0; bus.d_in = 32'd0; bus.in_valid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      env_mem[i] <= 32'h5A00_0000 + i * 32'h0001_0101;
      ref_mem[i] =  32'h5A00_0000 + i * 32'h0001_0101;
    end
    for (int i = 0; i < 32; i++) begin
      env_rf[i] <= 32'h00C0_0000 + i;
      ref_rf[i] =  32'h00C0_0000 + i;
    end
    repeat (3) step();
    chk("reset_outputs", -1, {bus.ctrlr_busy, bus.err, bus.rd_valid, bus.mcu_pause, bus.mcu_reset,
                              bus.mem_re, bus.mem_we, bus.rf_we}, 32'd0);
    chk("reset_d_rd", -1, bus.d_rd, 32'd0);
    reset_n = 1'b1;
    mon_en = 1'b1;
    step();

    // directed cases
    issue(4'd1, 32'd0, 32'd0, 3, 1, 1'b0);             // PAUSE, ack 3 cycles later -> busy 5
    env_mem[0] <= 32'hDEADBEEF;
    ref_mem[0] = 32'hDEADBEEF;
    issue(4'd5, 32'h100, 32'd0, 1, 3, 1'b0);           // MEM_RD -> mem_re 3 cycles
    issue(4'd6, 32'h102, 32'h1111, 1, 1, 1'b1);        // misaligned -> err
    issue(4'd8, 32'd5, 32'h1234, 1, 1, 1'b0);          // REG_WR x5
    issue(4'd7, 32'd5, 32'd0, 1, 1, 1'b0);             // REG_RD x5
    issue(4'd8, 32'd0, 32'hFFFF, 1, 1, 1'b0);          // REG_WR x0
    issue(4'd7, 32'd0, 32'd0, 1, 1, 1'b0);             // REG_RD x0
    issue(4'd6, 32'h140, 32'hCAFE_F00D, 1, 2, 1'b0);
    issue(4'd5, 32'h140, 32'd0, 1, 1, 1'b0);
    issue(4'd5, 32'h104, 32'd0, 1, 0, 1'b0);           // no ack -> 255 strobe cycles
    issue(4'd4, 32'd0, 32'd0, 1, 1, 1'b0);             // STATUS right after timeout
    issue(4'd1, 32'd0, 32'd0, 4, 1, 1'b0);             // already paused -> busy 2
    issue(4'd3, 32'd0, 32'd0, 1, 1, 1'b1);             // RESET -> 16 cycles
    issue(4'd12, 32'd0, 32'd0, 1, 1, 1'b0);            // invalid code
    issue(4'd0, 32'd0, 32'd0, 1, 1, 1'b1);             // NOP
    issue(4'd2, 32'd0, 32'd0, 1, 1, 1'b0);             // RESUME
    issue(4'd6, 32'h108, 32'h2222, 1, 1, 1'b0);        // MEM_WR unpaused -> err
    issue(4'd7, 32'd3, 32'd0, 1, 1, 1'b0);             // REG_RD unpaused -> err
    issue(4'd4, 32'd0, 32'd0, 1, 1, 1'b0);
    issue(4'd1, 32'd0, 32'd0, 0, 1, 1'b0);             // pause never acknowledged
    issue(4'd2, 32'd0, 32'd0, 1, 1, 1'b0);
    issue(4'd1, 32'd0, 32'd0, 1, 1, 1'b0);

    // randomized traffic
    for (int k = 0; k < 120; k++) begin
      int          r;
      logic [3:0]  c;
      logic [31:0] a;
      r = $urandom_range(0, 99);
      if      (r < 15) c = 4'd1;
      else if (r < 20) c = 4'd2;
      else if (r < 23) c = 4'd3;
      else if (r < 28) c = 4'd4;
      else if (r < 45) c = 4'd5;
      else if (r < 60) c = 4'd6;
      else if (r < 70) c = 4'd7;
      else if (r < 82) c = 4'd8;
      else if (r < 86) c = 4'd0;
      else             c = 4'($urandom_range(9, 15));
      a = 32'h100 + (32'($urandom_range(0, 63)) << 2);
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      if (c == 4'd7 || c == 4'd8) a = $urandom;
      issue(c, a, $urandom, $urandom_range(1, 6),
            ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 6), $urandom_range(0, 3) == 0);
    end

    // asynchronous reset in the middle of a memory read
    issue(4'd1, 32'd0, 32'd0, 1, 1, 1'b0);
    wait_idle(600);
    mon_en = 1'b0;
    ack_n = 0;
    bus.cmd = 4'd5; bus.addr = 32'h110; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    chk("arst_pre_mem_re", -2, bus.mem_re, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_outputs", -2, {bus.ctrlr_busy, bus.err, bus.rd_valid, bus.mcu_pause, bus.mcu_reset,
                             bus.mem_re, bus.mem_we, bus.rf_we}, 32'd0);
    chk("arst_d_rd", -2, bus.d_rd, 32'd0);
    repeat (2) step();
    reset_n = 1'b1;
    ref_pause = 1'b0;
    ref_last_rd = 32'd0;
    repeat (2) step();
    mon_en = 1'b1;
    step();
    issue(4'd4, 32'd0, 32'd0, 1, 1, 1'b0);
    issue(4'd7, 32'd5, 32'd0, 1, 1, 1'b0);             // unpaused after reset -> err
    wait_idle(600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
